mmio_char_fifo: RTL and testbench

MMIO_CHAR_FIFO -- requirements
Module: mmio_char_fifo

---
 rtl/mmio_char_fifo.sv | 133 +++++++++++++
 tb/tb_mmio_char_fifo.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_char_fifo.sv
// Memory-mapped character capture FIFO: CPU stores to a window of per-channel data registers
// are queued as (channel, byte) entries. Define MMIO_CHAR_FIFO_TIMESTAMP_EN to tag entries with a cycle stamp.
module mmio_char_fifo #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 16,
  parameter int                NUM_CH    = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'hE000_0000,
  localparam int               CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int               CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [7:0]        out_data,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic [15:0]       drop_cnt
`ifdef MMIO_CHAR_FIFO_TIMESTAMP_EN
  ,
  output logic [31:0]       out_ts
`endif
);

  localparam int                PTR_W     = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] WIN_BYTES = ADDR_W'(4 * NUM_CH);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  logic [7:0]        data_mem [DEPTH];
  logic [CH_W-1:0]   ch_mem   [DEPTH];

  logic [ADDR_W-1:0] offset;
  logic              capture, clr, pop, push, drop, full;
  logic [CH_W-1:0]   cap_ch;
  logic              unused_wdata;

  // Subtracting the base first lets one unsigned compare reject addresses both below and above the window.
  assign offset       = mem_addr - BASE_ADDR;
  assign capture      = mem_we && (mem_addr[1:0] == 2'b00) && (offset < WIN_BYTES);
  assign clr          = mem_we && (offset == WIN_BYTES);
  assign cap_ch       = offset[CH_W+1:2];
  assign unused_wdata = ^mem_wdata;

  assign full = (count_q == FULL_CNT);
  assign pop  = (count_q != '0) && out_ready;
  assign push = capture && (!full || pop);
  assign drop = capture && full && !pop;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= mem_wdata[7:0];
      ch_mem[wr_ptr_q]   <= cap_ch;
    end
  end

  // Head fields are forced to zero when empty so reset presents clean outputs.
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? data_mem[rd_ptr_q] : 8'h00;
  assign out_ch    = out_valid ? ch_mem[rd_ptr_q] : '0;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

`ifdef MMIO_CHAR_FIFO_TIMESTAMP_EN
  logic [31:0] ts_q;
  logic [31:0] ts_mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ts_q <= '0;
    else      ts_q <= ts_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) ts_mem[wr_ptr_q] <= ts_q;
  end

  assign out_ts = out_valid ? ts_mem[rd_ptr_q] : 32'h0;
`else
  // Without timestamps each entry carries only channel and byte.
`endif

endmodule

// File: tb/tb_mmio_char_fifo.sv
// Randomized bench for mmio_char_fifo, compared every cycle against a queue-based reference model.
module tb_mmio_char_fifo;
  localparam int          ADDR_W = 32;
  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 16;
  localparam int          NUM_CH = 4;
  localparam logic [31:0] BASE   = 32'hE000_0000;
  localparam logic [31:0] CLR    = BASE + 32'(4 * NUM_CH);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              mem_we = 1'b0;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [DATA_W-1:0] mem_wdata = '0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [1:0]        out_ch;
  logic [7:0]        out_data;
  logic [4:0]        count;
  logic              overflow;
  logic [15:0]       drop_cnt;
`ifdef MMIO_CHAR_FIFO_TIMESTAMP_EN
  logic [31:0]       out_ts;
`endif

  mmio_char_fifo #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
`ifdef MMIO_CHAR_FIFO_TIMESTAMP_EN
    , .out_ts(out_ts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    int          ch;
    logic [31:0] ts;
  } ent_t;

  ent_t        q[$];
  bit          mdl_ovf;
  int          mdl_drop;
  logic [31:0] mdl_ts;
  int          n_cmp;
  int          n_fail;
  bit          stream_en;
  logic [7:0]  rx[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of captured entries plus the drop bookkeeping.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      mdl_ovf  = 1'b0;
      mdl_drop = 0;
      mdl_ts   = 32'h0;
    end else begin
      bit   cap, clr_hit, do_pop;
      int   pre;
      ent_t e;
      cap     = mem_we && (mem_addr[1:0] == 2'b00) && (mem_addr >= BASE) && (mem_addr < CLR);
      clr_hit = mem_we && (mem_addr == CLR);
      pre     = q.size();
      do_pop  = out_ready && (pre > 0);
      if (do_pop) void'(q.pop_front());
      if (cap) begin
        if (pre < DEPTH || do_pop) begin
          e.data = mem_wdata[7:0];
          e.ch   = int'((mem_addr - BASE) / 4);
          e.ts   = mdl_ts;
          q.push_back(e);
        end else begin
          mdl_ovf = 1'b1;
          if (mdl_drop < 16'hFFFF) mdl_drop++;
        end
      end
      if (clr_hit) begin
        mdl_ovf  = 1'b0;
        mdl_drop = 0;
      end
      mdl_ts = mdl_ts + 1;
    end
  end

  // Single compare process, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("count", 32'(count), 32'(q.size()));
    check("overflow", 32'(overflow), 32'(mdl_ovf));
    check("drop_cnt", 32'(drop_cnt), 32'(mdl_drop));
    if (q.size() != 0) begin
      check("out_data", 32'(out_data), 32'(q[0].data));
      check("out_ch", 32'(out_ch), 32'(q[0].ch));
`ifdef MMIO_CHAR_FIFO_TIMESTAMP_EN
      check("out_ts", out_ts, q[0].ts);
`endif
    end
    if (stream_en && out_valid && out_ready) rx.push_back(out_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    mem_we    = 1'b0;
    out_ready = rdy;
    repeat (n) tick();
  endtask

  task automatic store(input logic [31:0] addr, input logic [7:0] data, input logic rdy);
    mem_we    = 1'b1;
    mem_addr  = addr;
    mem_wdata = {$urandom_range(0, 32'hFF_FFFF), data};
    out_ready = rdy;
    tick();
    mem_we    = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    @(posedge clk);
    #4;
    rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    int sent;
    int pct;
    int sel;
    logic [31:0] a;

    // Reset state
    tick();
    tick();
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_count", 32'(count), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_out_ch", 32'(out_ch), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_drop_cnt", 32'(drop_cnt), 32'd0);
    rst = 1'b1;

    // Single capture falls through on the next cycle
    store(BASE + 32'd4, 8'h48, 1'b0);
    check("fwft_valid", 32'(out_valid), 32'd1);
    check("fwft_ch", 32'(out_ch), 32'd1);
    check("fwft_data", 32'(out_data), 32'h48);
    check("fwft_count", 32'(count), 32'd1);
    idle(1, 1'b1);
    check("pop_count", 32'(count), 32'd0);
    idle(1, 1'b1);
    check("ready_when_empty", 32'(count), 32'd0);

    // Misaligned and out-of-window stores are ignored
    store(BASE + 32'd2, 8'h11, 1'b0);
    store(CLR + 32'd4, 8'h22, 1'b0);
    check("ignored_count", 32'(count), 32'd0);
    check("ignored_valid", 32'(out_valid), 32'd0);

    // Overflow then clear
    for (int i = 0; i < DEPTH + 3; i++) store(BASE, 8'(i), 1'b0);
    check("full_count", 32'(count), 32'(DEPTH));
    check("full_overflow", 32'(overflow), 32'd1);
    check("full_drop_cnt", 32'(drop_cnt), 32'd3);
    check("full_head", 32'(out_data), 32'd0);
    store(CLR, 8'h00, 1'b0);
    check("clr_overflow", 32'(overflow), 32'd0);
    check("clr_drop_cnt", 32'(drop_cnt), 32'd0);
    check("clr_count", 32'(count), 32'(DEPTH));

    // Capture with pop while full is accepted
    store(BASE + 32'd8, 8'hAA, 1'b1);
    check("fullpop_count", 32'(count), 32'(DEPTH));
    check("fullpop_drop", 32'(drop_cnt), 32'd0);
    check("fullpop_head", 32'(out_data), 32'd1);
    idle(DEPTH, 1'b1);
    check("drained", 32'(count), 32'd0);

    // Ordered stream across pointer wrap with random back-pressure
    stream_en = 1'b1;
    sent      = 0;
    cycles    = 0;
    while ((sent < 3 * DEPTH || q.size() != 0) && cycles < 5000) begin
      if (sent < 3 * DEPTH && q.size() < DEPTH && $urandom_range(0, 3) != 0) begin
        mem_we    = 1'b1;
        mem_addr  = BASE + 32'(4 * $urandom_range(0, NUM_CH - 1));
        mem_wdata = 32'(sent);
        sent++;
      end else begin
        mem_we = 1'b0;
      end
      out_ready = 1'($urandom_range(0, 1));
      tick();
      cycles++;
    end
    mem_we    = 1'b0;
    out_ready = 1'b0;
    stream_en = 1'b0;
    check("stream_in_time", 32'(cycles < 5000), 32'd1);
    check("stream_len", 32'(rx.size()), 32'(3 * DEPTH));
    foreach (rx[i]) check("stream_order", 32'(rx[i]), 32'(i));

    // Reset mid-operation discards entries
    for (int i = 0; i < 5; i++) store(BASE + 32'd12, 8'(8'h60 + i), 1'b0);
    #3;
    pulse_reset();
    store(BASE + 32'd8, 8'h41, 1'b0);
    check("post_rst_head", 32'(out_data), 32'h41);
    check("post_rst_ch", 32'(out_ch), 32'd2);
    check("post_rst_count", 32'(count), 32'd1);
    idle(1, 1'b1);

    // Random traffic with varying back-pressure
    for (int blk = 0; blk < 8; blk++) begin
      pct = $urandom_range(5, 95);
      for (int c = 0; c < 200; c++) begin
        sel = $urandom_range(0, 19);
        if (sel < 12)       a = BASE + 32'(4 * $urandom_range(0, NUM_CH - 1));
        else if (sel < 14)  a = BASE + 32'(4 * $urandom_range(0, NUM_CH - 1)) + 32'($urandom_range(1, 3));
        else if (sel == 14) a = CLR;
        else if (sel == 15) a = BASE - 32'd4;
        else if (sel == 16) a = CLR + 32'd4;
        else                a = BASE;
        mem_we    = (sel < 17) ? 1'b1 : 1'($urandom_range(0, 1));
        mem_addr  = a;
        mem_wdata = $urandom;
        out_ready = ($urandom_range(0, 99) < pct);
        tick();
      end
    end
    idle(DEPTH + 2, 1'b1);
    check("final_empty", 32'(count), 32'd0);

`ifdef MMIO_CHAR_FIFO_TIMESTAMP_EN
    begin
      logic [31:0] ts_a, ts_b;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      idle(10, 1'b0);
      store(BASE, 8'h01, 1'b0);
      idle(4, 1'b0);
      store(BASE, 8'h02, 1'b0);
      ts_a = out_ts;
      idle(1, 1'b1);
      ts_b = out_ts;
      out_ready = 1'b0;
      check("ts_first", ts_a, 32'd10);
      check("ts_second", ts_b, 32'd15);
      check("ts_delta", ts_b - ts_a, 32'd5);
      idle(2, 1'b1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
